// File: rtl/picoctrl_pkg.sv
// Shared definitions for the picoctrl sequencer and its program ROMs:
// instruction layout, condition/action codes and FSM state encoding.
package picoctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NREG    = 4;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'd0,
    COND_NEVER  = 4'd1,
    COND_C0_LO  = 4'd2,
    COND_C0_HI  = 4'd3,
    COND_C1_LO  = 4'd4,
    COND_C1_HI  = 4'd5,
    COND_C2_LO  = 4'd6,
    COND_C2_HI  = 4'd7,
    COND_C3_LO  = 4'd8,
    COND_C3_HI  = 4'd9
  } cond_e;

  typedef enum logic [1:0] {
    ACT_NOP   = 2'b00,
    ACT_WRITE = 2'b01,
    ACT_JUMP  = 2'b10,
    ACT_HALT  = 2'b11
  } action_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // cond=[15:12], action=[11:10], reg_sel=[9:8], data=[7:0]
  typedef struct packed {
    logic [3:0]        cond;
    action_e           action;
    logic [1:0]        reg_sel;
    logic [DATA_W-1:0] data;
  } instr_t;

  function automatic instr_t mk_instr(cond_e c, action_e a, logic [1:0] sel,
                                      logic [DATA_W-1:0] d);
    instr_t i;
    i.cond    = c;
    i.action  = a;
    i.reg_sel = sel;
    i.data    = d;
    return i;
  endfunction

endpackage

// File: rtl/picoctrl_sequencer_if.sv
// Bus bundle between the sequencer (master) and its ROM/host environment (slave).
interface picoctrl_sequencer_if
  import picoctrl_pkg::*;
#(
  parameter int unsigned PC_W  = 5,
  parameter int unsigned NCOND = 4
);

  logic                start;
  logic                stop;
  logic [NCOND-1:0]    cond_in;
  logic [PC_W-1:0]     rom_addr;
  logic [INSTR_W-1:0]  rom_data;
  logic [DATA_W-1:0]   reg0;
  logic [DATA_W-1:0]   reg1;
  logic [DATA_W-1:0]   reg2;
  logic [DATA_W-1:0]   reg3;
  logic                wr_stb;
  logic                busy;
  logic [PC_W-1:0]     pc_out;

  modport master (
    input  start, stop, cond_in, rom_data,
    output rom_addr, reg0, reg1, reg2, reg3, wr_stb, busy, pc_out
  );

  modport slave (
    output start, stop, cond_in, rom_data,
    input  rom_addr, reg0, reg1, reg2, reg3, wr_stb, busy, pc_out
  );

endinterface

// File: rtl/picoctrl_cond_sync.sv
// Two-flop synchronizer for the asynchronous condition inputs.
module picoctrl_cond_sync #(
  parameter int unsigned NCOND = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCOND-1:0] d_i,
  output logic [NCOND-1:0] q_o
);

  logic [NCOND-1:0] meta_q;
  logic [NCOND-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/picoctrl_sequencer.sv
// Two-cycle FETCH/EXEC micro-sequencer driving four output registers from an
// external combinational program ROM.
module picoctrl_sequencer
  import picoctrl_pkg::*;
#(
  parameter int unsigned PC_W  = 5,
  parameter int unsigned NCOND = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  picoctrl_sequencer_if.master bus
);

  state_e                       state_q, state_d;
  logic [PC_W-1:0]              pc_q, pc_d;
  instr_t                       ir_q, ir_d;
  logic [NREG-1:0][DATA_W-1:0]  reg_q, reg_d;
  logic                         wr_stb_q, wr_stb_d;
  logic                         busy_q, busy_d;
  logic [NCOND-1:0]             cond_s;
  logic [3:0]                   cond4_c;
  logic                         cond_true_c;

  picoctrl_cond_sync #(.NCOND(NCOND)) u_cond_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.cond_in),
    .q_o     (cond_s)
  );

  assign cond4_c = 4'(cond_s);

  // Condition decode on synchronized inputs; unused codes read as "never".
  always_comb begin
    cond_true_c = 1'b0;
    case (ir_q.cond)
      COND_ALWAYS: cond_true_c = 1'b1;
      COND_C0_LO:  cond_true_c = !cond4_c[0];
      COND_C0_HI:  cond_true_c =  cond4_c[0];
      COND_C1_LO:  cond_true_c = !cond4_c[1];
      COND_C1_HI:  cond_true_c =  cond4_c[1];
      COND_C2_LO:  cond_true_c = !cond4_c[2];
      COND_C2_HI:  cond_true_c =  cond4_c[2];
      COND_C3_LO:  cond_true_c = !cond4_c[3];
      COND_C3_HI:  cond_true_c =  cond4_c[3];
      default:     cond_true_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    reg_d    = reg_q;
    wr_stb_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = instr_t'(bus.rom_data);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = bus.stop ? ST_IDLE : ST_FETCH;
        if (cond_true_c) begin
          case (ir_q.action)
            ACT_WRITE: begin
              reg_d[ir_q.reg_sel] = ir_q.data;
              wr_stb_d            = 1'b1;
            end
            ACT_JUMP:  pc_d    = PC_W'(ir_q.data);
            ACT_HALT:  state_d = ST_IDLE;
            default:   ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      reg_q    <= '0;
      wr_stb_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      reg_q    <= reg_d;
      wr_stb_q <= wr_stb_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.pc_out   = pc_q;
  assign bus.reg0     = reg_q[0];
  assign bus.reg1     = reg_q[1];
  assign bus.reg2     = reg_q[2];
  assign bus.reg3     = reg_q[3];
  assign bus.wr_stb   = wr_stb_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_picoctrl_sequencer.sv
// Self-checking bench: directed scenarios plus randomized programs checked
// against an instruction-level reference model.
module tb_picoctrl_sequencer;

  localparam int unsigned PC_W  = 5;
  localparam int unsigned NCOND = 4;
  localparam int          NWORD = 1 << PC_W;

  logic clk;
  logic reset_n;
  logic [15:0] rom [NWORD];
  int n_tests;
  int n_fail;

  picoctrl_sequencer_if #(.PC_W(PC_W), .NCOND(NCOND)) bus ();

  picoctrl_sequencer #(.PC_W(PC_W), .NCOND(NCOND)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: running flag, execute-phase flag, pc, ir, registers.
  bit         m_run;
  bit         m_exec;
  int         m_pc;
  logic [15:0] m_ir;
  logic [7:0] m_reg [4];
  bit         m_wr;
  logic [3:0] m_s1, m_s2;

  function automatic bit cond_ok(int code, logic [3:0] s);
    if (code == 0) return 1'b1;
    if (code >= 2 && code <= 9) return s[(code - 2) / 2] == ((code - 2) % 2);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_exec = 0; m_pc = 0; m_ir = '0; m_wr = 0;
    m_s1 = '0; m_s2 = '0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
  endtask

  task automatic model_edge(input bit st, input bit sp, input logic [3:0] c);
    int code, act, sel, dat, next_pc;
    bit go_idle, nxt_wr;
    nxt_wr = 0;
    if (!m_run) begin
      if (st && !sp) begin m_run = 1; m_exec = 0; end
    end else if (!m_exec) begin
      m_ir = rom[m_pc];
      m_exec = 1;
    end else begin
      code = int'(m_ir[15:12]); act = int'(m_ir[11:10]);
      sel  = int'(m_ir[9:8]);   dat = int'(m_ir[7:0]);
      next_pc = (m_pc + 1) % NWORD;
      go_idle = sp;
      if (cond_ok(code, m_s2)) begin
        if (act == 1) begin m_reg[sel] = 8'(dat); nxt_wr = 1; end
        else if (act == 2) next_pc = dat % NWORD;
        else if (act == 3) go_idle = 1;
      end
      m_pc = next_pc;
      m_exec = 0;
      if (go_idle) m_run = 0;
    end
    m_wr = nxt_wr;
    m_s2 = m_s1;
    m_s1 = c;
  endtask

  function automatic logic [49:0] model_vec();
    return {m_run, m_wr, 8'(m_pc), 8'(m_pc), m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
  endfunction

  function automatic logic [49:0] dut_vec();
    return {bus.busy, bus.wr_stb, 8'(bus.pc_out), 8'(bus.rom_addr),
            bus.reg3, bus.reg2, bus.reg1, bus.reg0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (reset_n) model_edge(bus.start, bus.stop, 4'(bus.cond_in));
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.start = 0; bus.stop = 0; bus.cond_in = '0;
    reset_n = 0;
    model_reset();
    #2;
    reset_n = 1;
  endtask

  task automatic pulse_start();
    bus.start = 1;
    cyc();
    bus.start = 0;
  endtask

  task automatic fill_halt();
    for (int a = 0; a < NWORD; a++) rom[a] = 16'h0C00;
  endtask

  task automatic test_reset();
    fill_halt();
    do_reset();
    n_tests++;
    if ({bus.busy, bus.wr_stb, 5'(bus.pc_out)} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %0h exp 0", {bus.busy, bus.wr_stb, bus.pc_out});
    end
    n_tests++;
    if ({bus.reg3, bus.reg2, bus.reg1, bus.reg0} !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs got %0h exp 0", {bus.reg3, bus.reg2, bus.reg1, bus.reg0});
    end
    for (int k = 0; k < 4; k++) cyc();
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out)} !== 6'b0) begin
      n_fail++; $display("FAIL reset_quiet got %0h exp 0", {bus.busy, bus.pc_out});
    end
  endtask

  task automatic test_write();
    fill_halt();
    rom[0] = 16'h0401;
    do_reset();
    pulse_start();
    cyc();
    cyc();
    n_tests++;
    if ({bus.reg0, bus.wr_stb, 5'(bus.pc_out), bus.busy} !== {8'h01, 1'b1, 5'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL write_cycle3 got reg0=%0h wr=%0b pc=%0d busy=%0b exp reg0=1 wr=1 pc=1 busy=1",
               bus.reg0, bus.wr_stb, bus.pc_out, bus.busy);
    end
    cyc();
    n_tests++;
    if ({bus.reg0, bus.wr_stb} !== {8'h01, 1'b0}) begin
      n_fail++; $display("FAIL write_stb_len got reg0=%0h wr=%0b exp reg0=1 wr=0", bus.reg0, bus.wr_stb);
    end
    for (int k = 0; k < 10 && bus.busy; k++) cyc();
    n_tests++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL write_end got %0h exp %0h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_jump_wait();
    int wrs;
    fill_halt();
    rom[0] = 16'h0000;
    rom[1] = 16'h5801;
    do_reset();
    bus.cond_in = 4'b0010;
    wrs = 0;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      cyc();
      wrs += int'(bus.wr_stb);
    end
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out)} !== {1'b1, 5'd1}) begin
      n_fail++; $display("FAIL jump_spin got busy=%0b pc=%0d exp busy=1 pc=1", bus.busy, bus.pc_out);
    end
    bus.cond_in = 4'b0000;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      cyc();
      wrs += int'(bus.wr_stb);
    end
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out)} !== {1'b0, 5'd3}) begin
      n_fail++; $display("FAIL jump_release got busy=%0b pc=%0d exp busy=0 pc=3", bus.busy, bus.pc_out);
    end
    n_tests++;
    if (wrs != 0) begin
      n_fail++; $display("FAIL jump_no_stb got %0d exp 0", wrs);
    end
  endtask

  task automatic test_walk();
    logic [7:0] seq [15];
    int idx, prev_pc, vec_err;
    bit wrap_seen;
    for (int i = 0; i < 15; i++) seq[i] = (i <= 7) ? 8'(1 << i) : 8'(1 << (14 - i));
    fill_halt();
    for (int i = 0; i < 15; i++) rom[i] = 16'h0400 | 16'(seq[i]);
    for (int i = 15; i < 31; i++) rom[i] = 16'h5500 | 16'(i);
    rom[31] = 16'h0000;
    do_reset();
    pulse_start();
    idx = 0; wrap_seen = 0; vec_err = 0;
    prev_pc = int'(bus.pc_out);
    for (int k = 0; k < 200; k++) begin
      bus.cond_in = ((k / 8) % 2 == 1) ? 4'b0010 : 4'b0000;
      cyc();
      if (dut_vec() !== model_vec()) vec_err++;
      if (bus.wr_stb && prev_pc < 15) begin
        n_tests++;
        if (bus.reg0 !== seq[idx % 15]) begin
          n_fail++; $display("FAIL walk_reg0[%0d] got %0h exp %0h", idx, bus.reg0, seq[idx % 15]);
        end
        idx++;
      end
      if (prev_pc == 31 && bus.pc_out == 5'd0) wrap_seen = 1;
      prev_pc = int'(bus.pc_out);
    end
    n_tests++;
    if (vec_err != 0) begin
      n_fail++; $display("FAIL walk_model got %0d cycle errors exp 0", vec_err);
    end
    n_tests++;
    if (!wrap_seen || idx < 30) begin
      n_fail++; $display("FAIL walk_wrap got wrap=%0b writes=%0d exp wrap=1 writes>=30", wrap_seen, idx);
    end
    bus.stop = 1;
    for (int k = 0; k < 6 && bus.busy; k++) cyc();
    bus.stop = 0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL walk_stop got busy=%0b exp 0", bus.busy);
    end
  endtask

  task automatic test_halt();
    fill_halt();
    for (int i = 0; i < 4; i++) rom[i] = 16'h0000;
    rom[5] = 16'h075A;
    do_reset();
    pulse_start();
    for (int k = 0; k < 30 && bus.busy; k++) cyc();
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out), bus.reg3} !== {1'b0, 5'd5, 8'h00}) begin
      n_fail++; $display("FAIL halt_stop got busy=%0b pc=%0d reg3=%0h exp busy=0 pc=5 reg3=0",
                         bus.busy, bus.pc_out, bus.reg3);
    end
    pulse_start();
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out)} !== {1'b1, 5'd5}) begin
      n_fail++; $display("FAIL halt_resume got busy=%0b pc=%0d exp busy=1 pc=5", bus.busy, bus.pc_out);
    end
    for (int k = 0; k < 30 && bus.busy; k++) cyc();
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out), bus.reg3} !== {1'b0, 5'd7, 8'h5A}) begin
      n_fail++; $display("FAIL halt_second got busy=%0b pc=%0d reg3=%0h exp busy=0 pc=7 reg3=5a",
                         bus.busy, bus.pc_out, bus.reg3);
    end
  endtask

  task automatic test_stop();
    bit found;
    fill_halt();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0633; rom[3] = 16'h0000;
    do_reset();
    pulse_start();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.busy && bus.pc_out == 5'd2) found = 1;
      else cyc();
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL stop_reach got pc=%0d exp 2 (timeout)", bus.pc_out);
    end
    bus.stop = 1;
    cyc();
    cyc();
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out), bus.reg2} !== {1'b0, 5'd3, 8'h33}) begin
      n_fail++; $display("FAIL stop_exec got busy=%0b pc=%0d reg2=%0h exp busy=0 pc=3 reg2=33",
                         bus.busy, bus.pc_out, bus.reg2);
    end
    bus.start = 1;
    for (int k = 0; k < 4; k++) cyc();
    bus.start = 0; bus.stop = 0;
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out)} !== {1'b0, 5'd3}) begin
      n_fail++; $display("FAIL stop_wins got busy=%0b pc=%0d exp busy=0 pc=3", bus.busy, bus.pc_out);
    end
  endtask

  task automatic test_reset_mid();
    int wrs;
    fill_halt();
    rom[0] = 16'h06A5;
    do_reset();
    pulse_start();
    cyc();
    reset_n = 0;
    model_reset();
    #2;
    reset_n = 1;
    wrs = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      wrs += int'(bus.wr_stb);
    end
    n_tests++;
    if ({bus.busy, 5'(bus.pc_out), bus.reg2} !== {1'b0, 5'd0, 8'h00} || wrs != 0) begin
      n_fail++; $display("FAIL reset_mid got busy=%0b pc=%0d reg2=%0h wrs=%0d exp 0 0 0 0",
                         bus.busy, bus.pc_out, bus.reg2, wrs);
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic [1:0] a;
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < NWORD; i++) begin
        c = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
        a = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
        rom[i] = {c, a, 2'($urandom % 4), 8'($urandom % 256)};
      end
      do_reset();
      for (int k = 0; k < 300; k++) begin
        bus.start = ($urandom % 4 == 0);
        bus.stop  = ($urandom % 20 == 0);
        if ($urandom % 4 == 0) bus.cond_in = 4'($urandom);
        cyc();
        n_tests++;
        if (dut_vec() !== model_vec()) begin
          n_fail++; $display("FAIL random[%0d.%0d] got %0h exp %0h", p, k, dut_vec(), model_vec());
        end
      end
    end
    bus.start = 0; bus.stop = 0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    bus.start = 0; bus.stop = 0; bus.cond_in = '0;
    reset_n = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write();
    test_jump_wait();
    test_walk();
    test_halt();
    test_stop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/picoctrl_sequencer.md
PICOCTRL_SEQUENCER -- requirements
Module: picoctrl_sequencer

Interface
REQ-001 Parameter PC_W, default 5, meaning program-counter / ROM address width (32-word program).
REQ-002 Parameter NCOND, default 4, meaning number of external condition inputs c0..c3.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  run request, sampled in IDLE.
REQ-006 stop  input  1  halt request, honoured at end of current EXEC.
REQ-007 cond_in  input  NCOND  asynchronous condition inputs c[3:0].
REQ-008 rom_addr  output  PC_W  instruction address to combinational program ROM (equals pc).
REQ-009 rom_data  input  16  instruction word returned by ROM in the same cycle.
REQ-010 reg0..reg3  output  8 each  general output registers.
REQ-011 wr_stb  output  1  one-cycle pulse, high the cycle after any register write.
REQ-012 busy  output  1  high in FETCH or EXEC.
REQ-013 pc_out  output  PC_W  current program counter, for debug.

Function
REQ-014 Instruction fields: cond=[15:12], action=[11:10], reg_sel=[9:8], data=[7:0].
REQ-015 Cond codes: 0 always, 1 never, 2 c0==0, 3 c0==1, 4 c1==0, 5 c1==1, 6 c2==0, 7 c2==1, 8 c3==0, 9 c3==1, 10-15 never.
REQ-016 Actions: 00 nop, 01 write reg[reg_sel]<=data, 10 jump pc<=data[PC_W-1:0] (upper data bits ignored), 11 halt.
REQ-017 FSM states: IDLE, FETCH, EXEC; encoding is free.
REQ-018 IDLE: start=1 and stop=0 -> FETCH next cycle; otherwise remain; pc holds.
REQ-019 FETCH: ir<=rom_data at address pc; -> EXEC unconditionally (one cycle).
REQ-020 EXEC: cond evaluated on synchronized inputs, action taken when true; -> FETCH, or IDLE if stop=1 or taken halt.
REQ-021 Each instruction takes exactly 2 cycles; FETCH-to-FETCH spacing is 2 cycles.
REQ-022 pc update in EXEC: taken jump -> target; all other cases (incl. halt, untaken jump) -> pc+1 modulo 2^PC_W (31 wraps to 0).
REQ-023 Jump to own address with a true condition spins there (wait loop) until the condition flips or stop is asserted.
REQ-024 Register write visible on regN the cycle after EXEC; wr_stb high that same cycle only.
REQ-025 Untaken write, nop, and condition "never" produce no register change and no wr_stb.
REQ-026 start and stop high together in IDLE: stop wins, stay IDLE.
REQ-027 Halt resumes from pc+1 on next start; no implicit return to 0.
REQ-028 cond_in passes through a 2-flop synchronizer; condition latency from pin to EXEC decision is 2 clk edges.

Reset
REQ-029 reset_n low asynchronously forces: state IDLE, pc 0, ir 0, reg0..reg3 0x00, wr_stb 0, busy 0, synchronizer flops 0.
REQ-030 Reset asserted mid-EXEC aborts the instruction; no partial write survives.
REQ-031 After reset_n deasserts, no activity until start.

Structure
REQ-032 Field positions, cond codes, action codes and state encoding live in shared package picoctrl_pkg, also used by ROM programs.
REQ-033 One sub-module, picoctrl_cond_sync (NCOND-wide 2-flop synchronizer with async active-low reset), instantiated once.
REQ-034 No ROM inside this block; program ROM stays a separate combinational module driven by rom_addr.

Verification
REQ-035 Reset, start pulse, ROM[0]={always,write,reg0,0x01} -> reg0=0x01 at cycle 3 after start, wr_stb 1 cycle, pc=1.
REQ-036 ROM[1]={c1==1,jump,0x01}, c1 held 1 for 10 cycles then 0 -> pc stays 1 while c1 synced high, then advances to 2, no wr_stb.
REQ-037 Walking-bit program 0x01..0x80..0x01 with c1 toggled every 8 cycles -> reg0 sequence matches, pc wraps 0x1F->0x00.
REQ-038 ROM[4]={always,halt}, then start -> busy low after EXEC of 4, pc=5; second start resumes at 5.
REQ-039 stop asserted during FETCH of addr 2 -> EXEC of addr 2 completes, then IDLE; start with stop high -> stays IDLE.
REQ-040 reset_n pulsed low mid-EXEC of a write to reg2=0xA5 -> reg2=0x00, pc=0, IDLE, wr_stb never high.
